// File: rtl/rv_core_pkg.sv
// Shared core constants and types for the register-file writeback sink.
// Optional write-through bypass is selected by the RF_BYPASS_EN macro.
package rv_core_pkg;
    localparam int XLEN_DEF     = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS_DEF = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]   xlen_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters with sticky overflow/underflow error,
// reporting raw pending and pending==1 flags for both read ports.
module reg_scoreboard
    import rv_core_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int PEND_W   = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_wb_enable,
    input  reg_addr_t i_wb_rd,
    input  logic      i_issue_valid,
    input  logic      i_issue_reg_write,
    input  reg_addr_t i_issue_rd,
    input  reg_addr_t i_rs1_addr,
    input  reg_addr_t i_rs2_addr,
    output logic      o_rs1_pend,
    output logic      o_rs1_pend_one,
    output logic      o_rs2_pend,
    output logic      o_rs2_pend_one,
    output logic      o_sb_error
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [PEND_W-1:0]   r_pend [NUM_REGS];
    logic                r_sb_error;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_ovf;
    logic [NUM_REGS-1:0] w_unf;

    // x0 is excluded here so it can never count or raise an error.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        w_ovf = '0;
        w_unf = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_inc[r] = (r != 0) && i_issue_valid && i_issue_reg_write &&
                       (i_issue_rd == REG_ADDR_W'(r));
            w_dec[r] = (r != 0) && i_wb_enable && (i_wb_rd == REG_ADDR_W'(r));
            w_ovf[r] = w_inc[r] && !w_dec[r] && (r_pend[r] == PEND_MAX);
            w_unf[r] = w_dec[r] && !w_inc[r] && (r_pend[r] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_pend[r] <= '0;
            end
            r_sb_error <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_inc[r] && !w_dec[r] && !w_ovf[r]) begin
                    r_pend[r] <= r_pend[r] + 1'b1;
                end else if (w_dec[r] && !w_inc[r] && !w_unf[r]) begin
                    r_pend[r] <= r_pend[r] - 1'b1;
                end
            end
            if ((|w_ovf) || (|w_unf)) begin
                r_sb_error <= 1'b1;
            end
        end
    end

    assign o_rs1_pend     = (i_rs1_addr != '0) && (r_pend[i_rs1_addr[AW-1:0]] != '0);
    assign o_rs1_pend_one = (i_rs1_addr != '0) && (r_pend[i_rs1_addr[AW-1:0]] == PEND_ONE);
    assign o_rs2_pend     = (i_rs2_addr != '0) && (r_pend[i_rs2_addr[AW-1:0]] != '0);
    assign o_rs2_pend_one = (i_rs2_addr != '0) && (r_pend[i_rs2_addr[AW-1:0]] == PEND_ONE);
    assign o_sb_error     = r_sb_error;
endmodule

// File: rtl/regfile_wb_sink.sv
// Architectural register file fed by writeback, with RAW hazard flags for decode.
// Define RF_BYPASS_EN to forward writeback data and resolve hazards in the wb cycle.
module regfile_wb_sink
    import rv_core_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int PEND_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_enable,
    input  reg_addr_t       wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            issue_valid,
    input  logic            issue_reg_write,
    input  reg_addr_t       issue_rd,
    input  reg_addr_t       rs1_addr,
    input  reg_addr_t       rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_hazard,
    output logic            rs2_hazard,
    output logic            sb_error
);
    localparam int AW = $clog2(NUM_REGS);

    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic            w_rs1_pend;
    logic            w_rs1_pend_one;
    logic            w_rs2_pend;
    logic            w_rs2_pend_one;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .PEND_W   (PEND_W)
    ) u_scoreboard (
        .clk               (clk),
        .rst               (rst),
        .i_wb_enable       (wb_enable),
        .i_wb_rd           (wb_rd),
        .i_issue_valid     (issue_valid),
        .i_issue_reg_write (issue_reg_write),
        .i_issue_rd        (issue_rd),
        .i_rs1_addr        (rs1_addr),
        .i_rs2_addr        (rs2_addr),
        .o_rs1_pend        (w_rs1_pend),
        .o_rs1_pend_one    (w_rs1_pend_one),
        .o_rs2_pend        (w_rs2_pend),
        .o_rs2_pend_one    (w_rs2_pend_one),
        .o_sb_error        (sb_error)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else if (wb_enable && (wb_rd != '0)) begin
            r_regs[wb_rd[AW-1:0]] <= wb_data;
        end
    end

`ifdef RF_BYPASS_EN
    logic w_rs1_wb_hit;
    logic w_rs2_wb_hit;

    assign w_rs1_wb_hit = wb_enable && (wb_rd != '0) && (wb_rd == rs1_addr);
    assign w_rs2_wb_hit = wb_enable && (wb_rd != '0) && (wb_rd == rs2_addr);

    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if (rs1_addr != '0) w_rs1_data = r_regs[rs1_addr[AW-1:0]];
        if (rs2_addr != '0) w_rs2_data = r_regs[rs2_addr[AW-1:0]];
        if (w_rs1_wb_hit)   w_rs1_data = wb_data;
        if (w_rs2_wb_hit)   w_rs2_data = wb_data;
    end

    // Only the last outstanding write may clear the hazard in its own wb cycle.
    assign rs1_hazard = w_rs1_pend && !(w_rs1_pend_one && w_rs1_wb_hit);
    assign rs2_hazard = w_rs2_pend && !(w_rs2_pend_one && w_rs2_wb_hit);
`else
    logic w_unused_pend_one;

    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if (rs1_addr != '0) w_rs1_data = r_regs[rs1_addr[AW-1:0]];
        if (rs2_addr != '0) w_rs2_data = r_regs[rs2_addr[AW-1:0]];
    end

    assign rs1_hazard        = w_rs1_pend;
    assign rs2_hazard        = w_rs2_pend;
    assign w_unused_pend_one = w_rs1_pend_one ^ w_rs2_pend_one;
`endif

    assign rs1_data = w_rs1_data;
    assign rs2_data = w_rs2_data;
endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed bench for regfile_wb_sink; expectations follow RF_BYPASS_EN when defined.
module tb_regfile_wb_sink;
    import rv_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_enable;
    reg_addr_t   wb_rd;
    logic [31:0] wb_data;
    logic        issue_valid;
    logic        issue_reg_write;
    reg_addr_t   issue_rd;
    reg_addr_t   rs1_addr;
    reg_addr_t   rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_hazard;
    logic        rs2_hazard;
    logic        sb_error;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_wb_sink dut (
        .clk             (clk),
        .rst             (rst),
        .wb_enable       (wb_enable),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .issue_valid     (issue_valid),
        .issue_reg_write (issue_reg_write),
        .issue_rd        (issue_rd),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .rs1_hazard      (rs1_hazard),
        .rs2_hazard      (rs2_hazard),
        .sb_error        (sb_error)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks are taken 1 time unit after inputs change, mid-cycle.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        #1;
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic en, input reg_addr_t rd, input logic [31:0] d);
        wb_enable = en;
        wb_rd     = rd;
        wb_data   = d;
    endtask

    task automatic issue(input logic v, input reg_addr_t rd);
        issue_valid     = v;
        issue_reg_write = v;
        issue_rd        = rd;
    endtask

    initial begin
        rst = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        issue(1'b0, 5'd0);
        rs1_addr = 5'd5;
        rs2_addr = 5'd31;

        // Reset then read
        tick(); tick();
        rst = 1'b0;
        check("rst_rs1_data", rs1_data, 32'h0);
        check("rst_rs2_data", rs2_data, 32'h0);
        check("rst_rs1_haz", {31'b0, rs1_hazard}, 32'h0);
        check("rst_rs2_haz", {31'b0, rs2_hazard}, 32'h0);
        check("rst_sb_error", {31'b0, sb_error}, 32'h0);

        // Write x0 (discarded) then x7; the x7 writeback has no pending issue
        wb(1'b1, 5'd0, 32'hDEADBEEF);
        tick();
        wb(1'b1, 5'd7, 32'hDEADBEEF);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        rs1_addr = 5'd0;
        rs2_addr = 5'd7;
        check("x0_read", rs1_data, 32'h0);
        check("x7_read", rs2_data, 32'hDEADBEEF);
        check("x7_unf_err", {31'b0, sb_error}, 32'h1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_sb_error", {31'b0, sb_error}, 32'h0);
        check("rst2_x7_clear", rs2_data, 32'h0);

        // Single hazard lifecycle on x3
        rs1_addr = 5'd3;
        issue(1'b1, 5'd3);
        check("x3_haz_issue_cyc", {31'b0, rs1_hazard}, 32'h0);
        tick();
        issue(1'b0, 5'd0);
        check("x3_haz_after_issue", {31'b0, rs1_hazard}, 32'h1);
        tick(); tick();
        wb(1'b1, 5'd3, 32'h11);
`ifdef RF_BYPASS_EN
        check("x3_haz_wb_cyc", {31'b0, rs1_hazard}, 32'h0);
        check("x3_data_wb_cyc", rs1_data, 32'h11);
`else
        check("x3_haz_wb_cyc", {31'b0, rs1_hazard}, 32'h1);
        check("x3_data_wb_cyc", rs1_data, 32'h0);
`endif
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("x3_haz_after_wb", {31'b0, rs1_hazard}, 32'h0);
        check("x3_data_after_wb", rs1_data, 32'h11);

        // Back-to-back writes to x4
        rs2_addr = 5'd4;
        issue(1'b1, 5'd4);
        tick(); tick();
        issue(1'b0, 5'd0);
        check("x4_haz_pend2", {31'b0, rs2_hazard}, 32'h1);
        wb(1'b1, 5'd4, 32'hA);
        check("x4_haz_first_wb", {31'b0, rs2_hazard}, 32'h1);
        tick();
        wb(1'b1, 5'd4, 32'hB);
`ifdef RF_BYPASS_EN
        check("x4_haz_second_wb", {31'b0, rs2_hazard}, 32'h0);
        check("x4_data_second_wb", rs2_data, 32'hB);
`else
        check("x4_haz_second_wb", {31'b0, rs2_hazard}, 32'h1);
        check("x4_data_second_wb", rs2_data, 32'hA);
`endif
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("x4_haz_done", {31'b0, rs2_hazard}, 32'h0);
        check("x4_data_done", rs2_data, 32'hB);

        // Simultaneous inc/dec on x9 with one write already outstanding
        rs1_addr = 5'd9;
        issue(1'b1, 5'd9);
        tick();
        wb(1'b1, 5'd9, 32'h99);
        tick();
        issue(1'b0, 5'd0);
        wb(1'b0, 5'd0, 32'h0);
        check("x9_haz_held", {31'b0, rs1_hazard}, 32'h1);
        check("x9_data", rs1_data, 32'h99);
        wb(1'b1, 5'd9, 32'h9A);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("x9_haz_clear", {31'b0, rs1_hazard}, 32'h0);
        check("x9_no_err", {31'b0, sb_error}, 32'h0);

        // Overflow: four issues to x2 saturate at 3
        rs1_addr = 5'd2;
        issue(1'b1, 5'd2);
        tick(); tick(); tick();
        check("x2_no_err_at_max", {31'b0, sb_error}, 32'h0);
        tick();
        issue(1'b0, 5'd0);
        check("x2_haz_sat", {31'b0, rs1_hazard}, 32'h1);
        check("x2_ovf_err", {31'b0, sb_error}, 32'h1);
        wb(1'b1, 5'd2, 32'h22);
        tick(); tick();
        wb(1'b0, 5'd0, 32'h0);
        check("x2_haz_after_2wb", {31'b0, rs1_hazard}, 32'h1);
        wb(1'b1, 5'd2, 32'h23);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("x2_haz_after_3wb", {31'b0, rs1_hazard}, 32'h0);

        // Underflow on x6 after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst3_sb_error", {31'b0, sb_error}, 32'h0);
        rs2_addr = 5'd6;
        wb(1'b1, 5'd6, 32'h66);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("x6_unf_err", {31'b0, sb_error}, 32'h1);
        check("x6_haz", {31'b0, rs2_hazard}, 32'h0);
        check("x6_data", rs2_data, 32'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
